ins_fetch_unit: RTL and testbench

- Responder side of the control-signal interface: consumes CS_PC_load / CS_PC_inc / CS_Ins_load from the control FSM.
- Owns the program counter, performs the instruction-ROM read handshake and splits the word into fields.
- Returns the opcode, plus a busy/done indication, so the control FSM can sequence its load, execute and 2-byte states.
- Sits between the control FSM and the instruction ROM.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/fetch_pc.sv | 35 +++
 rtl/ins_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_ins_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, instruction field positions and the
// fetch FSM state type used by the instruction fetch unit.
package cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_DEC  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_NAND = 4'h8;
    localparam logic [3:0] OP_NOR  = 4'h9;
    localparam logic [3:0] OP_XNOR = 4'hA;
    localparam logic [3:0] OP_MOV  = 4'hB;
    localparam logic [3:0] OP_MVI  = 4'hC;
    localparam logic [3:0] OP_LDA  = 4'hD;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int DST_HI  = 11;
    localparam int DST_LO  = 9;
    localparam int SRC1_HI = 8;
    localparam int SRC1_LO = 6;
    localparam int SRC2_HI = 5;
    localparam int SRC2_LO = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_DONE     = 2'd2
    } fetch_state_e;

    // Instructions whose immediate/address lives in a second ROM word.
    function automatic logic is_two_word(input logic [3:0] opc);
        return (opc == OP_MVI) || (opc == OP_LDA);
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter with wrap-around increment and a registered copy used as
// the ROM fetch address.
module fetch_pc #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] pc_r;

    // PC and fetch address registers; load samples the pre-increment PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
            addr <= RESET_PC;
        end else begin
            if (inc) begin
                pc_r <= pc_r + ADDR_W'(1);
            end else begin
                pc_r <= pc_r;
            end
            if (load) begin
                addr <= pc_r;
            end else begin
                addr <= addr;
            end
        end
    end

endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: owns the PC, runs the ROM request/ack handshake
// with a timeout, and splits the fetched word into decoded fields.
module ins_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              CS_PC_load,
    input  logic              CS_PC_inc,
    input  logic              CS_Ins_load,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        FU_opcode,
    output logic [2:0]        FU_dst,
    output logic [2:0]        FU_src1,
    output logic [2:0]        FU_src2,
    output logic [DATA_W-1:0] FU_imm,
    output logic              FU_two_word,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              fetch_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e      state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [DATA_W-1:0] ir_r, ir_s, imm_r, imm_s;
    logic              word_sel_r, word_sel_s;
    logic              two_word_r, two_word_s;
    logic              req_r, req_s, done_r, done_s, err_r, err_s;
    logic              pc_load_s, pc_inc_s;

    fetch_pc #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk  (clk),
        .rst  (rst),
        .load (pc_load_s),
        .inc  (pc_inc_s),
        .addr (mem_addr)
    );

    // Next-state and datapath update for the fetch handshake.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        ir_s       = ir_r;
        imm_s      = imm_r;
        word_sel_s = word_sel_r;
        two_word_s = two_word_r;
        req_s      = req_r;
        done_s     = 1'b0;
        err_s      = 1'b0;
        pc_load_s  = 1'b0;
        pc_inc_s   = 1'b0;
        if (!en) begin
            state_s = ST_IDLE;
            req_s   = 1'b0;
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pc_load_s = CS_PC_load;
                    pc_inc_s  = CS_PC_inc;
                    if (CS_PC_load && CS_Ins_load) begin
                        req_s   = 1'b1;
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = ST_WAIT_ACK;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT_ACK: begin
                    if (mem_ack) begin
                        // First word carries the fields; a pending second word is the immediate.
                        if (!word_sel_r) begin
                            ir_s       = mem_rdata;
                            two_word_s = is_two_word(mem_rdata[OPC_HI:OPC_LO]);
                            word_sel_s = two_word_s;
                        end else begin
                            imm_s      = mem_rdata;
                            word_sel_s = 1'b0;
                        end
                        req_s   = 1'b0;
                        done_s  = 1'b1;
                        state_s = ST_DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        err_s   = 1'b1;
                        req_s   = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                    req_s   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            ir_r       <= {DATA_W{1'b0}};
            imm_r      <= {DATA_W{1'b0}};
            word_sel_r <= 1'b0;
            two_word_r <= 1'b0;
            req_r      <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            ir_r       <= ir_s;
            imm_r      <= imm_s;
            word_sel_r <= word_sel_s;
            two_word_r <= two_word_s;
            req_r      <= req_s;
            done_r     <= done_s;
            err_r      <= err_s;
        end
    end

    assign mem_req     = req_r;
    assign fetch_done  = done_r;
    assign fetch_err   = err_r;
    assign fetch_busy  = (state_r != ST_IDLE);
    assign FU_two_word = two_word_r;
    assign FU_imm      = imm_r;
    assign FU_opcode   = ir_r[OPC_HI:OPC_LO];
    assign FU_dst      = ir_r[DST_HI:DST_LO];
    assign FU_src1     = ir_r[SRC1_HI:SRC1_LO];
    assign FU_src2     = ir_r[SRC2_HI:SRC2_LO];

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Self-checking bench for ins_fetch_unit: decode table, hand-written corner
// sequences and a randomized run against a behavioural fetch model.
module tb_ins_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, en, CS_PC_load, CS_PC_inc, CS_Ins_load, mem_ack;
    logic [15:0] mem_rdata;
    logic [7:0]  mem_addr;
    logic        mem_req, FU_two_word, fetch_busy, fetch_done, fetch_err;
    logic [3:0]  FU_opcode;
    logic [2:0]  FU_dst, FU_src1, FU_src2;
    logic [15:0] FU_imm;

    ins_fetch_unit dut (
        .clk(clk), .rst(rst), .en(en),
        .CS_PC_load(CS_PC_load), .CS_PC_inc(CS_PC_inc), .CS_Ins_load(CS_Ins_load),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .FU_opcode(FU_opcode), .FU_dst(FU_dst), .FU_src1(FU_src1), .FU_src2(FU_src2),
        .FU_imm(FU_imm), .FU_two_word(FU_two_word),
        .fetch_busy(fetch_busy), .fetch_done(fetch_done), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model of architectural state
    int          pc_m;
    logic [15:0] ir_m, imm_m;
    logic        ws_m, tw_m;
    logic [15:0] rom [256];

    typedef struct {
        logic [15:0] word;
        int          lat;
        logic [3:0]  opc;
        logic [2:0]  dst, s1, s2;
        logic        tw;
        logic [15:0] imm;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cs(input logic l, input logic i, input logic n);
        CS_PC_load  = l;
        CS_Ins_load = i;
        CS_PC_inc   = n;
    endtask

    function automatic logic two_word_op(input logic [15:0] w);
        return (w[15:12] == 4'hC) || (w[15:12] == 4'hD);
    endfunction

    task automatic chk_fields(input string tag);
        chk({tag, ".opc"},  32'(FU_opcode),   32'(ir_m[15:12]));
        chk({tag, ".dst"},  32'(FU_dst),      32'(ir_m[11:9]));
        chk({tag, ".src1"}, 32'(FU_src1),     32'(ir_m[8:6]));
        chk({tag, ".src2"}, 32'(FU_src2),     32'(ir_m[5:3]));
        chk({tag, ".imm"},  32'(FU_imm),      32'(imm_m));
        chk({tag, ".tw"},   32'(FU_two_word), 32'(tw_m));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".req"},  32'(mem_req),    32'd0);
        chk({tag, ".busy"}, 32'(fetch_busy), 32'd0);
        chk({tag, ".done"}, 32'(fetch_done), 32'd0);
        chk({tag, ".err"},  32'(fetch_err),  32'd0);
    endtask

    task automatic noise_cs;
        cs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Full fetch: start, lat idle request cycles, ack, done pulse, back to idle.
    task automatic fetch(input int lat, input logic inc, input logic [15:0] data, input logic noise);
        logic [7:0] a;
        a = 8'(pc_m);
        cs(1'b1, 1'b1, inc);
        tick;
        cs(1'b0, 1'b0, 1'b0);
        if (inc) pc_m = (pc_m + 1) % 256;
        chk("start.req",  32'(mem_req),    32'd1);
        chk("start.busy", 32'(fetch_busy), 32'd1);
        chk("start.addr", 32'(mem_addr),   32'(a));
        for (int i = 0; i < lat; i++) begin
            if (noise) noise_cs();
            tick;
            chk("wait.req",      32'(mem_req),                 32'd1);
            chk("wait.addr",     32'(mem_addr),                32'(a));
            chk("wait.done_err", 32'({fetch_done, fetch_err}), 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick;
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        if (!ws_m) begin
            ir_m = data;
            tw_m = two_word_op(data);
            ws_m = tw_m;
        end else begin
            imm_m = data;
            ws_m  = 1'b0;
        end
        chk("ack.done", 32'(fetch_done), 32'd1);
        chk("ack.err",  32'(fetch_err),  32'd0);
        chk("ack.req",  32'(mem_req),    32'd0);
        chk("ack.busy", 32'(fetch_busy), 32'd1);
        chk_fields("ack");
        if (noise) noise_cs();
        tick;
        cs(1'b0, 1'b0, 1'b0);
        chk("post.done", 32'(fetch_done), 32'd0);
        chk("post.busy", 32'(fetch_busy), 32'd0);
        chk("post.addr", 32'(mem_addr),   32'(a));
    endtask

    task automatic inc_pc(input int n);
        for (int i = 0; i < n; i++) begin
            cs(1'b0, 1'b0, 1'b1);
            tick;
            pc_m = (pc_m + 1) % 256;
        end
        cs(1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_check(input string tag);
        cs(1'b1, 1'b0, 1'b0);
        tick;
        cs(1'b0, 1'b0, 1'b0);
        chk(tag, 32'(mem_addr), 32'(pc_m));
        chk({tag, ".req"}, 32'(mem_req), 32'd0);
    endtask

    task automatic model_reset;
        pc_m  = 0;
        ir_m  = 16'h0000;
        imm_m = 16'h0000;
        ws_m  = 1'b0;
        tw_m  = 1'b0;
    endtask

    initial begin
        tbl[0] = '{16'h0A58, 3,  4'h0, 3'd5, 3'd1, 3'd3, 1'b0, 16'h0000};
        tbl[1] = '{16'hB6D0, 0,  4'hB, 3'd3, 3'd3, 3'd2, 1'b0, 16'h0000};
        tbl[2] = '{16'hC200, 1,  4'hC, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0000};
        tbl[3] = '{16'h1234, 2,  4'hC, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234};
        tbl[4] = '{16'h7FFF, 14, 4'h7, 3'd7, 3'd7, 3'd7, 1'b0, 16'h1234};
        tbl[5] = '{16'hD000, 5,  4'hD, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234};
        tbl[6] = '{16'hABCD, 0,  4'hD, 3'd0, 3'd0, 3'd0, 1'b1, 16'hABCD};
        tbl[7] = '{16'h4C91, 4,  4'h4, 3'd6, 3'd2, 3'd2, 1'b0, 16'hABCD};
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rom[i][15:13] = 3'b110;
        end

        // Reset state
        rst = 1'b1; en = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0000;
        cs(1'b0, 1'b0, 1'b0);
        tick; tick;
        rst = 1'b0;
        model_reset();
        chk("rst.addr", 32'(mem_addr), 32'd0);
        chk_quiet("rst");
        chk_fields("rst");

        // Decode table, one fetch per entry with PC increment
        for (int i = 0; i < 8; i++) begin
            fetch(tbl[i].lat, 1'b1, tbl[i].word, 1'b0);
            chk("tbl.opc",  32'(FU_opcode),   32'(tbl[i].opc));
            chk("tbl.dst",  32'(FU_dst),      32'(tbl[i].dst));
            chk("tbl.src1", 32'(FU_src1),     32'(tbl[i].s1));
            chk("tbl.src2", 32'(FU_src2),     32'(tbl[i].s2));
            chk("tbl.tw",   32'(FU_two_word), 32'(tbl[i].tw));
            chk("tbl.imm",  32'(FU_imm),      32'(tbl[i].imm));
        end

        // Reset in the middle of a fetch, then a late ack
        inc_pc(1);
        cs(1'b1, 1'b1, 1'b0);
        tick;
        cs(1'b0, 1'b0, 1'b0);
        chk("mid.addr9", 32'(mem_addr), 32'd9);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        model_reset();
        chk("mid.addr", 32'(mem_addr), 32'd0);
        chk_quiet("mid");
        chk_fields("mid");
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        tick;
        mem_ack = 1'b0;
        chk_quiet("late");
        chk_fields("late");
        load_check("mid.pc0");

        // Two-word MVI at ROM[4]/ROM[5], then a single-word fetch
        inc_pc(4);
        fetch(2, 1'b1, 16'hC200, 1'b0);
        chk("mvi.tw", 32'(FU_two_word), 32'd1);
        fetch(0, 1'b1, 16'h1234, 1'b0);
        chk("mvi.imm", 32'(FU_imm),    32'h1234);
        chk("mvi.opc", 32'(FU_opcode), 32'hC);
        fetch(1, 1'b0, 16'h0A58, 1'b0);
        chk("mvi.next_opc", 32'(FU_opcode),   32'h0);
        chk("mvi.next_tw",  32'(FU_two_word), 32'd0);

        // Ack timeout
        cs(1'b1, 1'b1, 1'b0);
        tick;
        cs(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            tick;
            chk("to.req",      32'(mem_req),                 32'd1);
            chk("to.done_err", 32'({fetch_done, fetch_err}), 32'd0);
        end
        tick;
        chk("to.err",  32'(fetch_err),  32'd1);
        chk("to.req0", 32'(mem_req),    32'd0);
        chk("to.busy", 32'(fetch_busy), 32'd0);
        chk("to.done", 32'(fetch_done), 32'd0);
        chk_fields("to");
        tick;
        chk("to.err_pulse", 32'(fetch_err), 32'd0);
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        tick;
        mem_ack = 1'b0;
        chk_quiet("stray");
        chk_fields("stray");

        // Abort via en low during WAIT_ACK
        cs(1'b1, 1'b1, 1'b1);
        tick;
        cs(1'b0, 1'b0, 1'b0);
        pc_m = (pc_m + 1) % 256;
        tick;
        en = 1'b0;
        tick;
        chk_quiet("abort");
        cs(1'b1, 1'b1, 1'b1);
        mem_ack = 1'b1; mem_rdata = 16'hEEEE;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_quiet("dis");
            chk_fields("dis");
        end
        cs(1'b0, 1'b0, 1'b0);
        mem_ack = 1'b0;
        en = 1'b1;
        load_check("abort.pc");
        fetch(4, 1'b0, 16'h3A1C, 1'b1);

        // Randomized operations against the model
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 4))
                0, 1: fetch(int'($urandom_range(0, 14)), 1'($urandom_range(0, 1)), rom[pc_m], 1'b1);
                2: begin
                    logic inc;
                    inc = 1'($urandom_range(0, 1));
                    cs(1'b1, 1'b0, inc);
                    tick;
                    cs(1'b0, 1'b0, 1'b0);
                    chk("rnd.load", 32'(mem_addr), 32'(pc_m));
                    chk_quiet("rnd.load");
                    if (inc) pc_m = (pc_m + 1) % 256;
                end
                3: begin
                    cs(1'b0, 1'b1, 1'b1);
                    tick;
                    cs(1'b0, 1'b0, 1'b0);
                    pc_m = (pc_m + 1) % 256;
                    chk_quiet("rnd.insonly");
                end
                default: begin
                    mem_ack = 1'b1; mem_rdata = 16'($urandom);
                    tick;
                    mem_ack = 1'b0;
                    chk_quiet("rnd.stray");
                    chk_fields("rnd.stray");
                end
            endcase
        end

        // PC wrap, then start and increment in the same cycle at pc = 7
        inc_pc((255 - pc_m + 256) % 256);
        load_check("wrap.ff");
        inc_pc(1);
        load_check("wrap.00");
        inc_pc(7);
        fetch(0, 1'b1, 16'h0A58, 1'b0);
        load_check("startinc.pc8");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
